// File: rtl/mm_pkg.sv
// Shared types and helpers for the Mastermind game controller.
//   game_state_t  : top-level game flow (touch handling, rows, win/lose)
//   score_state_t : scorer sequencing (exact matches, then per-colour matches)
//   cw_for/pw_for/rw_for : field widths derived from the game parameters
//   field_get/field_put  : access peg k of a packed row vector; rows up to
//                          MAX_VEC bits wide, fields up to MAX_FIELD bits
package mm_pkg;

    localparam int MAX_VEC   = 64;
    localparam int MAX_FIELD = 8;

    typedef enum logic [2:0] {
        IDLE,
        EDIT,
        SCORING,
        WON,
        LOST
    } game_state_t;

    typedef enum logic [1:0] {
        SC_IDLE,
        SCORE_BLACK,
        SCORE_COLOR,
        SCORE_DONE
    } score_state_t;

    function automatic int bits_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cw_for(input int num_colors);
        return bits_for(num_colors + 1);
    endfunction

    function automatic int pw_for(input int num_pegs);
        return bits_for(num_pegs + 1);
    endfunction

    function automatic int rw_for(input int num_rows);
        return bits_for(num_rows);
    endfunction

    function automatic logic [MAX_FIELD-1:0] field_get(input logic [MAX_VEC-1:0] vec,
                                                       input int k, input int w);
        logic [MAX_VEC-1:0] mask;
        mask = (MAX_VEC'(1) << w) - MAX_VEC'(1);
        return MAX_FIELD'((vec >> (k * w)) & mask);
    endfunction

    function automatic logic [MAX_VEC-1:0] field_put(input logic [MAX_VEC-1:0] vec,
                                                     input int k, input int w,
                                                     input logic [MAX_FIELD-1:0] val);
        logic [MAX_VEC-1:0] mask;
        mask = ((MAX_VEC'(1) << w) - MAX_VEC'(1)) << (k * w);
        return (vec & ~mask) | ((MAX_VEC'(val) << (k * w)) & mask);
    endfunction

endpackage

// File: rtl/mm_game_engine_scorer.sv
// Multi-cycle Mastermind scorer. On start it snapshots guess and secret,
// counts exact matches in one cycle, then walks colours 1..NUM_COLORS
// accumulating min(count in guess, count in secret). done pulses for one
// cycle with black/white valid. A start in any state restarts scoring.
// Ports:
//   clock, reset     : system clock, async active-high reset
//   start            : begin scoring the presented guess/secret
//   guess, secret    : packed rows, peg k at [k*CW +: CW]
//   done             : one-cycle strobe, black/white valid
//   black, white     : exact matches, colour-only matches
//
// state       | meaning
// SC_IDLE     | waiting for start
// SCORE_BLACK | count exact position+colour matches
// SCORE_COLOR | one colour per cycle, accumulate total colour matches
// SCORE_DONE  | result valid, done asserted
module mm_peg_scorer
    import mm_pkg::*;
#(
    parameter int NUM_PEGS   = 4,
    parameter int NUM_COLORS = 6,
    localparam int CW = cw_for(NUM_COLORS),
    localparam int PW = pw_for(NUM_PEGS),
    localparam int GW = NUM_PEGS * CW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [GW-1:0] guess,
    input  logic [GW-1:0] secret,
    output logic          done,
    output logic [PW-1:0] black,
    output logic [PW-1:0] white
);

    score_state_t  state, state_nxt;
    logic [GW-1:0] g_snap, s_snap;
    logic [CW-1:0] color;
    logic [CW-1:0] gf, sf;
    logic [PW-1:0] match, exact_cnt, g_cnt, s_cnt, color_min;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= SC_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            SCORE_BLACK: state_nxt = SCORE_COLOR;
            SCORE_COLOR: if (color == CW'(NUM_COLORS)) state_nxt = SCORE_DONE;
            SCORE_DONE: begin
                done      = 1'b1;
                state_nxt = SC_IDLE;
            end
            default:     state_nxt = SC_IDLE;
        endcase
        if (start) state_nxt = SCORE_BLACK;
    end

    always_comb begin
        exact_cnt = '0;
        g_cnt     = '0;
        s_cnt     = '0;
        gf        = '0;
        sf        = '0;
        for (int k = 0; k < NUM_PEGS; k++) begin
            gf = CW'(field_get(MAX_VEC'(g_snap), k, CW));
            sf = CW'(field_get(MAX_VEC'(s_snap), k, CW));
            if (gf == sf)    exact_cnt = exact_cnt + PW'(1);
            if (gf == color) g_cnt     = g_cnt + PW'(1);
            if (sf == color) s_cnt     = s_cnt + PW'(1);
        end
        color_min = (g_cnt < s_cnt) ? g_cnt : s_cnt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            g_snap <= '0;
            s_snap <= '0;
            color  <= '0;
            match  <= '0;
            black  <= '0;
        end else if (start) begin
            g_snap <= guess;
            s_snap <= secret;
            color  <= CW'(1);
            match  <= '0;
        end else if (state == SCORE_BLACK) begin
            black <= exact_cnt;
        end else if (state == SCORE_COLOR) begin
            match <= match + color_min;
            if (color != CW'(NUM_COLORS)) color <= color + CW'(1);
        end
    end

    // Total colour matches always include the exact ones, so no underflow.
    assign white = match - black;

endmodule

// File: rtl/mm_game_engine.sv
// Mastermind game controller. Takes mapped touches (column, row), cycles peg
// colours on the active row, scores a submitted row with mm_peg_scorer and
// tracks win/lose. An accepted touch starts a holdoff window during which
// further touches are dropped.
// Ports:
//   clock, reset          : system clock, async active-high reset
//   new_game, secret_in   : start a game with the given secret
//   touch_valid/col/row   : mapped touch; col NUM_PEGS is the submit area
//   guess, active_row     : current editable row and its contents
//   black/white_pegs      : last score, qualified by score_valid pulse
//   busy                  : scoring in progress
//   game_won, game_lost   : end-of-game levels
//
// state   | meaning
// IDLE    | after reset, waiting for new_game
// EDIT    | touches edit the active row or submit it
// SCORING | scorer running, touches dropped
// WON     | last score was all black
// LOST    | last row scored without a win
module mm_game_engine
    import mm_pkg::*;
#(
    parameter int NUM_PEGS   = 4,
    parameter int NUM_COLORS = 6,
    parameter int NUM_ROWS   = 8,
    parameter int HOLDOFF    = 20000000,
    localparam int CW = cw_for(NUM_COLORS),
    localparam int PW = pw_for(NUM_PEGS),
    localparam int RW = rw_for(NUM_ROWS),
    localparam int TW = pw_for(NUM_PEGS),
    localparam int GW = NUM_PEGS * CW,
    localparam int HW = bits_for(HOLDOFF)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          new_game,
    input  logic [GW-1:0] secret_in,
    input  logic          touch_valid,
    input  logic [TW-1:0] touch_col,
    input  logic [RW-1:0] touch_row,
    output logic [GW-1:0] guess,
    output logic [RW-1:0] active_row,
    output logic [PW-1:0] black_pegs,
    output logic [PW-1:0] white_pegs,
    output logic          score_valid,
    output logic          busy,
    output logic          game_won,
    output logic          game_lost
);

    game_state_t   state, state_nxt;
    logic [GW-1:0] secret, secret_fixed, guess_inc;
    logic [HW-1:0] holdoff;
    logic [CW-1:0] cur_field, nxt_field;
    logic          accept, peg_touch, submit_touch, all_set, start;
    logic          sc_done;
    logic [PW-1:0] sc_black, sc_white;

    always_comb begin
        secret_fixed = secret_in;
        all_set      = 1'b1;
        for (int k = 0; k < NUM_PEGS; k++) begin
            // Empty secret pegs would be unmatchable; force them to colour 1.
            if (CW'(field_get(MAX_VEC'(secret_in), k, CW)) == '0)
                secret_fixed = GW'(field_put(MAX_VEC'(secret_fixed), k, CW, MAX_FIELD'(1)));
            if (CW'(field_get(MAX_VEC'(guess), k, CW)) == '0)
                all_set = 1'b0;
        end
    end

    always_comb begin
        cur_field = CW'(field_get(MAX_VEC'(guess), int'(touch_col), CW));
        if (cur_field == '0 || cur_field >= CW'(NUM_COLORS)) nxt_field = CW'(1);
        else                                                 nxt_field = cur_field + CW'(1);
        guess_inc = GW'(field_put(MAX_VEC'(guess), int'(touch_col), CW, MAX_FIELD'(nxt_field)));
    end

    assign accept       = (state == EDIT) && touch_valid && !new_game && (holdoff == '0)
                          && (touch_row == active_row) && (touch_col <= TW'(NUM_PEGS));
    assign peg_touch    = accept && (touch_col < TW'(NUM_PEGS));
    assign submit_touch = accept && (touch_col == TW'(NUM_PEGS));
    assign start        = submit_touch && all_set;
    assign busy         = (state == SCORING);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EDIT:    if (start) state_nxt = SCORING;
            SCORING: if (sc_done) begin
                if (sc_black == PW'(NUM_PEGS)) state_nxt = WON;
                else if (active_row == '0)     state_nxt = LOST;
                else                           state_nxt = EDIT;
            end
            default: state_nxt = state;
        endcase
        if (new_game) state_nxt = EDIT;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            secret      <= '0;
            guess       <= '0;
            active_row  <= RW'(NUM_ROWS - 1);
            black_pegs  <= '0;
            white_pegs  <= '0;
            score_valid <= 1'b0;
            game_won    <= 1'b0;
            game_lost   <= 1'b0;
            holdoff     <= '0;
        end else if (new_game) begin
            secret      <= secret_fixed;
            guess       <= '0;
            active_row  <= RW'(NUM_ROWS - 1);
            black_pegs  <= '0;
            white_pegs  <= '0;
            score_valid <= 1'b0;
            game_won    <= 1'b0;
            game_lost   <= 1'b0;
            holdoff     <= '0;
        end else begin
            score_valid <= 1'b0;
            // Submit with empty pegs still counts as accepted for holdoff.
            if (accept)              holdoff <= HW'(HOLDOFF - 1);
            else if (holdoff != '0)  holdoff <= holdoff - HW'(1);
            if (peg_touch) guess <= guess_inc;
            if (state == SCORING && sc_done) begin
                black_pegs  <= sc_black;
                white_pegs  <= sc_white;
                score_valid <= 1'b1;
                if (sc_black == PW'(NUM_PEGS)) begin
                    game_won <= 1'b1;
                end else if (active_row == '0) begin
                    game_lost <= 1'b1;
                end else begin
                    active_row <= active_row - RW'(1);
                    guess      <= '0;
                end
            end
        end
    end

    // A new_game mid-scoring leaves the scorer running; its done is ignored
    // outside SCORING, and the next start restarts it.
    mm_peg_scorer #(
        .NUM_PEGS   (NUM_PEGS),
        .NUM_COLORS (NUM_COLORS)
    ) u_scorer (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .guess  (guess),
        .secret (secret),
        .done   (sc_done),
        .black  (sc_black),
        .white  (sc_white)
    );

endmodule

// File: tb/tb_mm_game_engine.sv
module tb_mm_game_engine;

    localparam int NP = 4;
    localparam int NC = 6;
    localparam int NR = 8;
    localparam int H  = 4;
    localparam int CW = $clog2(NC + 1);
    localparam int PW = $clog2(NP + 1);
    localparam int RW = $clog2(NR);
    localparam int TW = $clog2(NP + 1);
    localparam int GW = NP * CW;

    logic          clock = 1'b0;
    logic          reset;
    logic          new_game;
    logic [GW-1:0] secret_in;
    logic          touch_valid;
    logic [TW-1:0] touch_col;
    logic [RW-1:0] touch_row;
    logic [GW-1:0] guess;
    logic [RW-1:0] active_row;
    logic [PW-1:0] black_pegs;
    logic [PW-1:0] white_pegs;
    logic          score_valid;
    logic          busy;
    logic          game_won;
    logic          game_lost;

    always #5 clock = ~clock;

    mm_game_engine #(
        .NUM_PEGS   (NP),
        .NUM_COLORS (NC),
        .NUM_ROWS   (NR),
        .HOLDOFF    (H)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .new_game    (new_game),
        .secret_in   (secret_in),
        .touch_valid (touch_valid),
        .touch_col   (touch_col),
        .touch_row   (touch_row),
        .guess       (guess),
        .active_row  (active_row),
        .black_pegs  (black_pegs),
        .white_pegs  (white_pegs),
        .score_valid (score_valid),
        .busy        (busy),
        .game_won    (game_won),
        .game_lost   (game_lost)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain game rules, scoring result delivered after a
    // fixed delay instead of being sequenced.
    int m_sec[NP];
    int m_g[NP];
    int m_row, m_blk, m_wht, m_hold, m_timer, m_pb, m_pw;
    bit m_sv, m_busy, m_won, m_lost, m_play;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [GW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [GW-1:0] v;
        v = '0;
        v[0*CW +: CW] = CW'(a);
        v[1*CW +: CW] = CW'(b);
        v[2*CW +: CW] = CW'(c);
        v[3*CW +: CW] = CW'(d);
        return v;
    endfunction

    function automatic void model_score(output int b, output int w);
        int m, gc, sc;
        b = 0;
        m = 0;
        for (int k = 0; k < NP; k++) if (m_g[k] == m_sec[k]) b++;
        for (int c = 1; c <= NC; c++) begin
            gc = 0;
            sc = 0;
            for (int k = 0; k < NP; k++) begin
                if (m_g[k] == c)   gc++;
                if (m_sec[k] == c) sc++;
            end
            m += (gc < sc) ? gc : sc;
        end
        w = m - b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NP; k++) begin
            m_sec[k] = 0;
            m_g[k]   = 0;
        end
        m_row = NR - 1; m_blk = 0; m_wht = 0; m_hold = 0; m_timer = 0;
        m_sv = 0; m_busy = 0; m_won = 0; m_lost = 0; m_play = 0;
    endtask

    task automatic model_edge(input bit ng, input bit tv, input int col, input int row,
                              input logic [GW-1:0] sec);
        bit acc, all;
        logic [GW-1:0] tmp;
        if (ng) begin
            for (int k = 0; k < NP; k++) begin
                tmp = sec >> (k * CW);
                m_sec[k] = int'(tmp[CW-1:0]);
                if (m_sec[k] == 0) m_sec[k] = 1;
                m_g[k] = 0;
            end
            m_row = NR - 1; m_blk = 0; m_wht = 0; m_hold = 0; m_timer = 0;
            m_sv = 0; m_busy = 0; m_won = 0; m_lost = 0; m_play = 1;
            return;
        end
        acc  = tv && m_play && !m_busy && (m_hold == 0) && (row == m_row) && (col <= NP);
        m_sv = 0;
        if (acc)             m_hold = H - 1;
        else if (m_hold > 0) m_hold--;
        if (m_busy) begin
            m_timer--;
            if (m_timer == 0) begin
                m_blk = m_pb; m_wht = m_pw; m_sv = 1; m_busy = 0;
                if (m_pb == NP) begin
                    m_won = 1; m_play = 0;
                end else if (m_row == 0) begin
                    m_lost = 1; m_play = 0;
                end else begin
                    m_row--;
                    for (int k = 0; k < NP; k++) m_g[k] = 0;
                end
            end
        end
        if (acc && col < NP)
            m_g[col] = (m_g[col] == 0 || m_g[col] >= NC) ? 1 : m_g[col] + 1;
        if (acc && col == NP) begin
            all = 1;
            for (int k = 0; k < NP; k++) if (m_g[k] == 0) all = 0;
            if (all) begin
                m_busy  = 1;
                m_timer = NC + 2;
                model_score(m_pb, m_pw);
            end
        end
    endtask

    task automatic compare_all();
        logic [GW-1:0] eg;
        eg = '0;
        for (int k = 0; k < NP; k++) eg[k*CW +: CW] = CW'(m_g[k]);
        check_val("guess",       guess,       eg);
        check_val("active_row",  active_row,  m_row);
        check_val("black",       black_pegs,  m_blk);
        check_val("white",       white_pegs,  m_wht);
        check_val("score_valid", score_valid, m_sv);
        check_val("busy",        busy,        m_busy);
        check_val("won",         game_won,    m_won);
        check_val("lost",        game_lost,   m_lost);
    endtask

    task automatic step(input bit ng, input bit tv, input int col, input int row,
                        input logic [GW-1:0] sec);
        new_game    = ng;
        touch_valid = tv;
        touch_col   = TW'(col);
        touch_row   = RW'(row);
        secret_in   = sec;
        @(posedge clock);
        model_edge(ng, tv, col, row, sec);
        #1;
        new_game    = 1'b0;
        touch_valid = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, '0);
    endtask

    task automatic touch(input int col);
        step(0, 1, col, m_row, '0);
        idle(H - 1);
    endtask

    task automatic set_guess(input int a, input int b, input int c, input int d);
        int t[NP];
        t[0] = a; t[1] = b; t[2] = c; t[3] = d;
        for (int k = 0; k < NP; k++)
            for (int i = 0; i <= NC && m_g[k] != t[k]; i++) touch(k);
    endtask

    task automatic submit_scored();
        int lat;
        step(0, 1, NP, m_row, '0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            lat++;
            if (score_valid === 1'b1) break;
        end
        check_val("score_latency", lat, NC + 2);
    endtask

    initial begin
        reset = 1'b1; new_game = 1'b0; touch_valid = 1'b0;
        touch_col = '0; touch_row = '0; secret_in = '0;
        #3;
        model_reset();
        compare_all();
        @(posedge clock);
        #1 reset = 1'b0;

        // Touches before any game are ignored.
        step(0, 1, 0, NR - 1, '0);

        // Directed game: secret (2,6,5,2), build (1,2,2,1).
        step(1, 0, 0, 0, pack4(2, 6, 5, 2));
        touch(0); touch(1); touch(1); touch(2); touch(2); touch(3);
        check_val("guess_1221", guess, 32'h291);
        check_val("row7", active_row, 7);

        // (2,5,2,1) scores black 1, white 2.
        set_guess(2, 5, 2, 1);
        submit_scored();
        check_val("b_2521", black_pegs, 1);
        check_val("w_2521", white_pegs, 2);
        check_val("row6", active_row, 6);
        check_val("guess_cleared", guess, 0);

        // Holdoff, wrong row, empty-peg submit reloading holdoff.
        step(0, 1, 0, 6, '0);
        step(0, 1, 0, 6, '0);
        step(0, 1, 1, 5, '0);
        idle(1);
        step(0, 1, NP, 6, '0);
        step(0, 1, 1, 6, '0);
        check_val("empty_submit_busy", busy, 0);
        check_val("guess_after_drops", guess, 32'h001);
        idle(H);

        // Winning guess; later touches ignored.
        set_guess(2, 6, 5, 2);
        submit_scored();
        check_val("b_win", black_pegs, 4);
        check_val("w_win", white_pegs, 0);
        check_val("won", game_won, 1);
        step(0, 1, 0, m_row, '0);
        step(0, 1, NP, m_row, '0);

        // Eight wrong guesses lose the game.
        step(1, 0, 0, 0, pack4(2, 6, 5, 2));
        for (int r = 0; r < NR; r++) begin
            set_guess(1, 1, 1, 1);
            submit_scored();
        end
        check_val("lost", game_lost, 1);
        check_val("row0", active_row, 0);

        // new_game wins over a simultaneous touch.
        step(1, 1, 0, NR - 1, pack4(0, 3, 0, 7));
        check_val("ng_touch_dropped", guess, 0);
        check_val("ng_row", active_row, NR - 1);

        // Secret (0,3,0,7) is held as (1,3,1,7).
        set_guess(3, 1, 1, 6);
        submit_scored();
        check_val("b_zero_secret", black_pegs, 1);
        check_val("w_zero_secret", white_pegs, 2);

        // Async reset in the middle of scoring.
        set_guess(1, 1, 1, 1);
        step(0, 1, NP, m_row, '0);
        idle(3);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #1 reset = 1'b0;
        compare_all();
        idle(12);

        // Randomised play.
        step(1, 0, 0, 0, pack4($urandom_range(0, NC), $urandom_range(0, NC),
                               $urandom_range(0, NC), $urandom_range(0, NC)));
        for (int i = 0; i < 3000; i++) begin
            bit ng, tv;
            int col, row;
            ng  = ($urandom % 300) == 0;
            tv  = ($urandom % 3) == 0;
            col = $urandom_range(0, NP);
            row = (($urandom % 8) == 0) ? $urandom_range(0, NR - 1) : m_row;
            if (!m_play && ($urandom % 20) == 0) ng = 1;
            step(ng, tv, col, row, pack4($urandom_range(0, NC), $urandom_range(0, NC),
                                         $urandom_range(0, NC), $urandom_range(0, NC)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
